// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The counter width depends on the operand width, so it is a function of dw.
package alu_muldiv_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring divide, chosen by mode_div.
// hi is the dw+1 bit accumulator/remainder, lo the multiplier/quotient, b the multiplicand/divisor.
module muldiv_step #(
  parameter int dw = 16
) (
  input  logic          mode_div,
  input  logic [dw:0]   hi,
  input  logic [dw-1:0] lo,
  input  logic [dw-1:0] b,
  output logic [dw:0]   hi_nxt,
  output logic [dw-1:0] lo_nxt
);

  logic [dw:0]   sum;
  logic [dw:0]   sh_hi;
  logic [dw+1:0] diff;

  always_comb begin
    sum    = hi + (lo[0] ? {1'b0, b} : '0);
    sh_hi  = {hi[dw-1:0], lo[dw-1]};
    // Top bit of diff is the borrow of the trial subtraction
    diff   = {1'b0, sh_hi} - {2'b00, b};
    hi_nxt = {1'b0, sum[dw:1]};
    lo_nxt = {sum[0], lo[dw-1:1]};
    if (mode_div) begin
      if (diff[dw+1]) begin
        hi_nxt = sh_hi;
        lo_nxt = {lo[dw-2:0], 1'b0};
      end else begin
        hi_nxt = diff[dw:0];
        lo_nxt = {lo[dw-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 MUL/DIV unit with start/busy/done handshake and RDY stall.
// Operands are reduced to magnitudes at start; signs are re-applied when results are registered.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int dw        = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RDY,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [dw-1:0] AI,
  input  logic [dw-1:0] BI,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] OUT_LO,
  output logic [dw-1:0] OUT_HI,
  output logic          Z,
  output logic          N,
  output logic          V
);

  localparam int CW = cnt_w(dw);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [dw:0]   hi, hi_nxt;
  logic [dw-1:0] lo, lo_nxt, b;
  logic          is_div, is_smul, neg_res, neg_rem, div_ovf;

  logic          op_sgn, a_neg, b_neg, b_zero, accept, ovf_in;
  logic [dw-1:0] a_mag, b_mag;

  assign op_sgn = SIGNED_EN && op[0];
  assign a_neg  = op_sgn & AI[dw-1];
  assign b_neg  = op_sgn & BI[dw-1];
  assign a_mag  = a_neg ? (~AI + 1'b1) : AI;
  assign b_mag  = b_neg ? (~BI + 1'b1) : BI;
  assign b_zero = op[1] && (BI == '0);
  assign accept = start && (state != S_RUN);
  // Most-negative / -1 needs no special datapath: the magnitude quotient wraps correctly
  assign ovf_in = op_sgn && op[1] && (AI == {1'b1, {(dw-1){1'b0}}}) && (BI == '1);

  muldiv_step #(.dw(dw)) u_step (
    .mode_div (is_div),
    .hi       (hi),
    .lo       (lo),
    .b        (b),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  logic [2*dw-1:0] prod;
  logic [dw-1:0]   quot, rem, res_lo, res_hi;
  logic            res_z, res_n, res_v;

  always_comb begin
    prod = {hi_nxt[dw-1:0], lo_nxt};
    if (neg_res) prod = ~prod + 1'b1;
    quot = neg_res ? (~lo_nxt + 1'b1) : lo_nxt;
    rem  = neg_rem ? (~hi_nxt[dw-1:0] + 1'b1) : hi_nxt[dw-1:0];
    if (is_div) begin
      res_lo = quot;
      res_hi = rem;
      res_z  = (quot == '0);
      res_n  = quot[dw-1];
      res_v  = div_ovf;
    end else begin
      res_lo = prod[dw-1:0];
      res_hi = prod[2*dw-1:dw];
      res_z  = (prod == '0);
      res_n  = prod[2*dw-1];
      res_v  = is_smul ? (res_hi != {dw{res_lo[dw-1]}}) : (res_hi != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  state <= S_IDLE;
    else if (RDY)  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)    state_nxt = b_zero ? S_DONE : S_RUN;
        else           state_nxt = S_IDLE;
      end
      S_RUN:           if (cnt == CW'(1)) state_nxt = S_DONE;
      default:         state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      b       <= '0;
      is_div  <= 1'b0;
      is_smul <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div_ovf <= 1'b0;
      OUT_LO  <= '0;
      OUT_HI  <= '0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
    end else if (RDY) begin
      if (accept) begin
        cnt     <= CW'(dw);
        hi      <= '0;
        lo      <= op[1] ? a_mag : b_mag;
        b       <= op[1] ? b_mag : a_mag;
        is_div  <= op[1];
        is_smul <= op_sgn && !op[1];
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        div_ovf <= ovf_in;
        if (b_zero) begin
          // All-ones quotient: Z=0, N=1 follow from OUT_LO directly
          OUT_LO <= '1;
          OUT_HI <= AI;
          Z      <= 1'b0;
          N      <= 1'b1;
          V      <= 1'b1;
        end
      end else if (state == S_RUN) begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          OUT_LO <= res_lo;
          OUT_HI <= res_hi;
          Z      <= res_z;
          N      <= res_n;
          V      <= res_v;
        end
      end
    end
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Iterative multiply/divide unit with parametrised width. It is the next-generation companion to the single-cycle ALU for the 6502, 65Org16 and wider cores. It executes unsigned or signed MUL/DIV as a radix-2 sequence of one bit per enabled cycle, behind a start/busy/done handshake. It honours the core RDY stall and produces a double-width result plus flags for the core's status register.

Parameters:
dw, 16, operand width in bits (8 for 6502, 16 for 65Org16, 32 for wider cores); legal range 4..64.
SIGNED_EN, 1, 1 enables the signed ops; 0 makes MULS behave as MULU and DIVS behave as DIVU.

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  synchronous, active-low reset
RDY  input  1  global enable; when low, all state, counters and outputs hold
start  input  1  request; sampled only when RDY=1 and not busy
op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS; sampled with start
AI  input  dw  multiplicand / dividend; sampled with start
BI  input  dw  multiplier / divisor; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse (extended while RDY=0): results valid
OUT_LO  output  dw  product low word / quotient
OUT_HI  output  dw  product high word / remainder
Z  output  1  result zero flag
N  output  1  result negative flag
V  output  1  overflow / divide-error flag

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-low on reset_n. On any rising edge with reset_n=0 (RDY ignored):
  - state=IDLE
  - busy=0, done=0
  - OUT_LO=0, OUT_HI=0
  - Z=0, N=0, V=0
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Start acceptance: start is accepted in IDLE or DONE when RDY=1. start is ignored in RUN.
- Transitions, on an edge with RDY=1:
  - IDLE/DONE + start, divisor nonzero or MUL op: latch operands. For signed ops, convert to magnitudes and record the result sign and remainder sign. Load count=dw. Go to RUN.
  - IDLE/DONE + start, DIV op with BI=0: go to DONE directly. done is high on the next cycle.
  - RUN: perform one step and decrement count. Once count reaches 0, register the sign-fixed results and flags and go to DONE.
  - DONE without start: go to IDLE.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+dw, counting RDY=1 edges only. For dw=16 that is 17 enabled edges from start to done.
- MUL step (shift-add): if multiplier LSB=1, add the multiplicand into the upper dw+1-bit accumulator. Then shift the {acc, multiplier} pair right by one.
- DIV step (restoring): shift {rem, quot} left by one. Trial-subtract the divisor from rem; if no borrow, keep the difference and set quot LSB=1.
- Signed results:
  - Product is negated if the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Flags, registered together with OUT in the transition into DONE:
  - Z = (OUT_HI==0 && OUT_LO==0) for MUL. Z = (OUT_LO==0) for DIV.
  - N = OUT_HI[dw-1] for MUL. N = OUT_LO[dw-1] for DIV.
  - V for MULU = (OUT_HI != 0).
  - V for MULS = OUT_HI not equal to the sign-extension of OUT_LO[dw-1].
  - V for DIV = divide-by-zero, or DIVS of the most-negative value by -1.
- Divide-by-zero: OUT_LO = all ones, OUT_HI = AI, V=1. Z and N are computed from OUT_LO.
- DIVS most-negative / -1: OUT_LO = 2^(dw-1) (the wrapped value), OUT_HI=0, V=1.
- Output hold: results and flags hold from DONE until the next result is registered. They are not cleared by leaving DONE.
- RDY=0: freezes state, count, datapath and all outputs. done stays high if the unit was in DONE.
- Back-to-back: start asserted during DONE begins a new operation. done deasserts on the next edge and busy asserts.

Decomposition:
- Package alu_muldiv_pkg holds:
  - op encodings OP_MULU, OP_MULS, OP_DIVU, OP_DIVS
  - state encoding S_IDLE, S_RUN, S_DONE
  - count width, defined as clog2(dw+1)
- One sub-module, muldiv_step: a purely combinational single radix-2 step (shift-add or restore-subtract, selected by mode). It is parametrised by dw and instantiated once.
- Sign conversion and the FSM stay in alu_muldiv.

Test Plan:
1. dw=16, MULU AI=0xFFFF BI=0xFFFF, RDY=1 -> done 17 cycles after start; OUT_HI=0xFFFE, OUT_LO=0x0001, V=1, Z=0, N=1.
2. MULS AI=0xFFFD (-3) BI=0x0005 -> OUT_HI=0xFFFF, OUT_LO=0xFFF1, V=0, N=1. Then DIVU AI=1000 BI=7 -> OUT_LO=0x008E, OUT_HI=0x0006, V=0.
3. DIVS AI=0xFFF9 (-7) BI=0x0002 -> OUT_LO=0xFFFD, OUT_HI=0xFFFF, N=1. Then DIVS AI=0x8000 BI=0xFFFF -> OUT_LO=0x8000, OUT_HI=0, V=1.
4. DIVU AI=0x1234 BI=0 -> done on the cycle after start, OUT_LO=0xFFFF, OUT_HI=0x1234, V=1. A start pulse during busy is ignored and the first result is unaffected.
5. MULU 0x0003*0x0004 with RDY held low for 5 cycles mid-RUN -> done delayed exactly 5 cycles; result 0x0000_000C; done stays high while RDY=0 in DONE.
6. reset_n=0 for one edge mid-RUN -> next cycle busy=0, done=0, all outputs 0; a new start then completes normally.
